// File: rtl/pipelined_control_unit.sv
// Main control for the 5-stage MIPS pipeline: ID-stage decode, ID/EX, EX/MEM and MEM/WB
// control registers, load-use stall generation and wrong-path flush on taken branches/jumps.
module pipelined_control_unit #(
    parameter int OP_W         = 6,
    parameter int REG_W        = 5,
    parameter int SUPPORT_IMM  = 1,
    parameter int SUPPORT_JUMP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  Opcode,
    input  logic [REG_W-1:0] IdRs,
    input  logic [REG_W-1:0] IdRt,
    input  logic             BranchTaken,
    output logic             Stall,
    output logic             FlushIfId,
    output logic [1:0]       IdJump,
    output logic             ExRegDst,
    output logic             ExALUSrc,
    output logic [1:0]       ExALUOp,
    output logic [2:0]       ExImmOp,
    output logic [1:0]       ExBranch,
    output logic [1:0]       MemMemRead,
    output logic [1:0]       MemMemWrite,
    output logic             WbRegWrite,
    output logic             WbMemtoReg,
    output logic             IllegalOp
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] imm_op;
        logic [1:0] branch;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BGEZ  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
    localparam logic [OP_W-1:0] OP_LB    = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] OP_LH    = OP_W'(6'b100001);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SB    = OP_W'(6'b101000);
    localparam logic [OP_W-1:0] OP_SH    = OP_W'(6'b101001);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

    ctrl_t            id_ctrl;
    logic [1:0]       id_jump_raw;
    logic             id_reads_rt;
    logic             load_use;
    logic             bubble;

    ctrl_t            ex_d,     ex_q;
    logic [REG_W-1:0] ex_rt_d,  ex_rt_q;
    mem_ctrl_t        mem_d,    mem_q;
    wb_ctrl_t         wb_d,     wb_q;

    always_comb begin
        id_ctrl     = '0;
        id_jump_raw = 2'b00;
        id_reads_rt = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                id_ctrl.reg_dst   = 1'b1;
                id_ctrl.reg_write = 1'b1;
                id_reads_rt       = 1'b1;
            end
            OP_LW, OP_LB, OP_LH: begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.alu_op     = 2'b01;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = (Opcode == OP_LW) ? 2'b01 :
                                     (Opcode == OP_LB) ? 2'b10 : 2'b11;
            end
            OP_SW, OP_SB, OP_SH: begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = 2'b01;
                id_ctrl.mem_write = (Opcode == OP_SW) ? 2'b01 :
                                    (Opcode == OP_SB) ? 2'b10 : 2'b11;
                id_reads_rt       = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGEZ: begin
                id_ctrl.alu_op = 2'b01;
                id_ctrl.branch = (Opcode == OP_BEQ) ? 2'b01 :
                                 (Opcode == OP_BNE) ? 2'b10 : 2'b11;
                // bgez uses the rt field as a sub-opcode, not a source register
                id_reads_rt    = (Opcode != OP_BGEZ);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: begin
                if (SUPPORT_IMM != 0) begin
                    id_ctrl.alu_src   = 1'b1;
                    id_ctrl.alu_op    = 2'b10;
                    id_ctrl.reg_write = 1'b1;
                    id_ctrl.imm_op    = Opcode[2:0];
                end else begin
                    id_ctrl.illegal = 1'b1;
                end
            end
            OP_J, OP_JAL: begin
                if (SUPPORT_JUMP != 0) begin
                    id_jump_raw = (Opcode == OP_J) ? 2'b01 : 2'b10;
                end else begin
                    id_ctrl.illegal = 1'b1;
                end
            end
            default: id_ctrl.illegal = 1'b1;
        endcase
    end

    // A bubble in EX has mem_read == 0, so it can never raise a second stall.
    always_comb begin
        load_use  = (ex_q.mem_read != 2'b00) && (ex_rt_q != '0) &&
                    ((ex_rt_q == IdRs) || ((ex_rt_q == IdRt) && id_reads_rt));
        Stall     = load_use && !BranchTaken;
        IdJump    = BranchTaken ? 2'b00 : id_jump_raw;
        FlushIfId = BranchTaken || (id_jump_raw != 2'b00);
        bubble    = BranchTaken || Stall;
    end

    always_comb begin
        ex_d             = bubble ? '0 : id_ctrl;
        ex_rt_d          = bubble ? '0 : IdRt;
        mem_d.mem_read   = ex_q.mem_read;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_to_reg = ex_q.mem_to_reg;
        wb_d.reg_write   = mem_q.reg_write;
        wb_d.mem_to_reg  = mem_q.mem_to_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ex_rt_q <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            ex_q    <= ex_d;
            ex_rt_q <= ex_rt_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    assign ExRegDst    = ex_q.reg_dst;
    assign ExALUSrc    = ex_q.alu_src;
    assign ExALUOp     = ex_q.alu_op;
    assign ExImmOp     = ex_q.imm_op;
    assign ExBranch    = ex_q.branch;
    assign IllegalOp   = ex_q.illegal;
    assign MemMemRead  = mem_q.mem_read;
    assign MemMemWrite = mem_q.mem_write;
    assign WbRegWrite  = wb_q.reg_write;
    assign WbMemtoReg  = wb_q.mem_to_reg;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: vector table with a scoreboard of expected EX bundles,
// plus hand sequences for the disabled-opcode variant and asynchronous reset.
module tb_pipelined_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [4:0] id_rs, id_rt;
    logic       branch_taken;

    logic       stall, flush_if_id, ex_reg_dst, ex_alu_src, wb_reg_write, wb_memto_reg, illegal_op;
    logic [1:0] id_jump, ex_alu_op, ex_branch, mem_mem_read, mem_mem_write;
    logic [2:0] ex_imm_op;

    logic       stall2, flush_if_id2, ex_reg_dst2, ex_alu_src2, wb_reg_write2, wb_memto_reg2, illegal_op2;
    logic [1:0] id_jump2, ex_alu_op2, ex_branch2, mem_mem_read2, mem_mem_write2;
    logic [2:0] ex_imm_op2;

    pipelined_control_unit #(.OP_W(6), .REG_W(5), .SUPPORT_IMM(1), .SUPPORT_JUMP(1)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(opcode), .IdRs(id_rs), .IdRt(id_rt),
        .BranchTaken(branch_taken), .Stall(stall), .FlushIfId(flush_if_id), .IdJump(id_jump),
        .ExRegDst(ex_reg_dst), .ExALUSrc(ex_alu_src), .ExALUOp(ex_alu_op), .ExImmOp(ex_imm_op),
        .ExBranch(ex_branch), .MemMemRead(mem_mem_read), .MemMemWrite(mem_mem_write),
        .WbRegWrite(wb_reg_write), .WbMemtoReg(wb_memto_reg), .IllegalOp(illegal_op)
    );

    pipelined_control_unit #(.OP_W(6), .REG_W(5), .SUPPORT_IMM(0), .SUPPORT_JUMP(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .Opcode(opcode), .IdRs(id_rs), .IdRt(id_rt),
        .BranchTaken(branch_taken), .Stall(stall2), .FlushIfId(flush_if_id2), .IdJump(id_jump2),
        .ExRegDst(ex_reg_dst2), .ExALUSrc(ex_alu_src2), .ExALUOp(ex_alu_op2), .ExImmOp(ex_imm_op2),
        .ExBranch(ex_branch2), .MemMemRead(mem_mem_read2), .MemMemWrite(mem_mem_write2),
        .WbRegWrite(wb_reg_write2), .WbMemtoReg(wb_memto_reg2), .IllegalOp(illegal_op2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic [2:0] imm_op;
        logic [1:0] branch;
        logic [1:0] mem_read;
        logic [1:0] mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       illegal;
    } bnd_t;

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       bt;
        logic       stall;
        logic       flush;
        logic [1:0] jump;
        bnd_t       ex;
    } vec_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, LB = 6'b100000, LH = 6'b100001;
    localparam logic [5:0] SW = 6'b101011, SB = 6'b101000, SH = 6'b101001;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGEZ = 6'b000001;
    localparam logic [5:0] ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
    localparam logic [5:0] SLTI = 6'b001010, LUI = 6'b001111, J = 6'b000010, JAL = 6'b000011;
    localparam logic [5:0] ILL = 6'b111111;

    localparam bnd_t B_Z    = '0;
    localparam bnd_t B_R    = '{reg_dst:1'b1, reg_write:1'b1, default:'0};
    localparam bnd_t B_LW   = '{alu_src:1'b1, alu_op:2'b01, mem_read:2'b01, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
    localparam bnd_t B_LB   = '{alu_src:1'b1, alu_op:2'b01, mem_read:2'b10, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
    localparam bnd_t B_LH   = '{alu_src:1'b1, alu_op:2'b01, mem_read:2'b11, reg_write:1'b1, mem_to_reg:1'b1, default:'0};
    localparam bnd_t B_SW   = '{alu_src:1'b1, alu_op:2'b01, mem_write:2'b01, default:'0};
    localparam bnd_t B_SB   = '{alu_src:1'b1, alu_op:2'b01, mem_write:2'b10, default:'0};
    localparam bnd_t B_SH   = '{alu_src:1'b1, alu_op:2'b01, mem_write:2'b11, default:'0};
    localparam bnd_t B_BEQ  = '{alu_op:2'b01, branch:2'b01, default:'0};
    localparam bnd_t B_BNE  = '{alu_op:2'b01, branch:2'b10, default:'0};
    localparam bnd_t B_BGEZ = '{alu_op:2'b01, branch:2'b11, default:'0};
    localparam bnd_t B_ADDI = '{alu_src:1'b1, alu_op:2'b10, imm_op:3'b000, reg_write:1'b1, default:'0};
    localparam bnd_t B_ANDI = '{alu_src:1'b1, alu_op:2'b10, imm_op:3'b100, reg_write:1'b1, default:'0};
    localparam bnd_t B_ORI  = '{alu_src:1'b1, alu_op:2'b10, imm_op:3'b101, reg_write:1'b1, default:'0};
    localparam bnd_t B_SLTI = '{alu_src:1'b1, alu_op:2'b10, imm_op:3'b010, reg_write:1'b1, default:'0};
    localparam bnd_t B_LUI  = '{alu_src:1'b1, alu_op:2'b10, imm_op:3'b111, reg_write:1'b1, default:'0};
    localparam bnd_t B_ILL  = '{illegal:1'b1, default:'0};

    vec_t tv[$];
    bnd_t sb_q[$];
    bnd_t exp_b, prev1, prev2;
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic bt, input logic st, input logic fl, input logic [1:0] jp,
                       input bnd_t ex);
        vec_t v;
        v.op = op; v.rs = rs; v.rt = rt; v.bt = bt;
        v.stall = st; v.flush = fl; v.jump = jp; v.ex = ex;
        tv.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] ex_part(input bnd_t b);
        return {b.reg_dst, b.alu_src, b.alu_op, b.imm_op, b.branch, b.illegal};
    endfunction

    function automatic logic [3:0] mem_part(input bnd_t b);
        return {b.mem_read, b.mem_write};
    endfunction

    function automatic logic [1:0] wb_part(input bnd_t b);
        return {b.reg_write, b.mem_to_reg};
    endfunction

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic bt);
        opcode = op; id_rs = rs; id_rt = rt; branch_taken = bt;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " ex"},  int'({ex_reg_dst, ex_alu_src, ex_alu_op, ex_imm_op, ex_branch}), 0);
        chk({nm, " mem"}, int'({mem_mem_read, mem_mem_write}), 0);
        chk({nm, " wb"},  int'({wb_reg_write, wb_memto_reg}), 0);
        chk({nm, " ill"}, int'(illegal_op), 0);
        chk({nm, " stall"}, int'(stall), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(R, 5'd0, 5'd0, 1'b0);
        prev1 = B_Z;
        prev2 = B_Z;

        //  op    rs  rt  bt  stall flush jump   ex-bundle
        add(LW,   1,  2,  0,  0,    0,    2'b00, B_LW);
        add(SW,   3,  4,  0,  0,    0,    2'b00, B_SW);
        add(R,    6,  7,  0,  0,    0,    2'b00, B_R);
        add(LB,   1,  8,  0,  0,    0,    2'b00, B_LB);
        add(SH,   9,  8,  0,  1,    0,    2'b00, B_Z);
        add(SH,   9,  8,  0,  0,    0,    2'b00, B_SH);
        add(LH,   0,  5,  0,  0,    0,    2'b00, B_LH);
        add(R,    5,  1,  0,  1,    0,    2'b00, B_Z);
        add(R,    5,  1,  0,  0,    0,    2'b00, B_R);
        add(LW,   1,  0,  0,  0,    0,    2'b00, B_LW);
        add(R,    0,  0,  0,  0,    0,    2'b00, B_R);
        add(LW,   1,  5,  0,  0,    0,    2'b00, B_LW);
        add(ADDI, 1,  5,  0,  0,    0,    2'b00, B_ADDI);
        add(LW,   2,  5,  0,  0,    0,    2'b00, B_LW);
        add(BEQ,  5,  6,  1,  0,    1,    2'b00, B_Z);
        add(J,    0,  0,  0,  0,    1,    2'b01, B_Z);
        add(JAL,  0,  0,  0,  0,    1,    2'b10, B_Z);
        add(JAL,  0,  0,  1,  0,    1,    2'b00, B_Z);
        add(BNE,  3,  4,  0,  0,    0,    2'b00, B_BNE);
        add(BGEZ, 3,  4,  0,  0,    0,    2'b00, B_BGEZ);
        add(ANDI, 1,  2,  0,  0,    0,    2'b00, B_ANDI);
        add(ORI,  1,  2,  0,  0,    0,    2'b00, B_ORI);
        add(SLTI, 1,  2,  0,  0,    0,    2'b00, B_SLTI);
        add(LUI,  1,  2,  0,  0,    0,    2'b00, B_LUI);
        add(ILL,  1,  2,  0,  0,    0,    2'b00, B_ILL);
        add(R,    1,  2,  0,  0,    0,    2'b00, B_R);
        add(LW,   1,  9,  0,  0,    0,    2'b00, B_LW);
        add(BEQ,  2,  9,  0,  1,    0,    2'b00, B_Z);
        add(BEQ,  2,  9,  0,  0,    0,    2'b00, B_BEQ);
        add(LW,   1,  9,  0,  0,    0,    2'b00, B_LW);
        add(BGEZ, 2,  9,  0,  0,    0,    2'b00, B_BGEZ);
        add(LW,   1,  9,  0,  0,    0,    2'b00, B_LW);
        add(ADDI, 9,  3,  0,  1,    0,    2'b00, B_Z);
        add(ADDI, 9,  3,  0,  0,    0,    2'b00, B_ADDI);
        add(LW,   1,  4,  0,  0,    0,    2'b00, B_LW);
        add(LW,   4,  6,  0,  1,    0,    2'b00, B_Z);
        add(LW,   4,  6,  0,  0,    0,    2'b00, B_LW);
        add(R,    6,  7,  0,  1,    0,    2'b00, B_Z);
        add(R,    6,  7,  0,  0,    0,    2'b00, B_R);
        add(SW,   1,  2,  0,  0,    0,    2'b00, B_SW);
        add(SB,   1,  2,  0,  0,    0,    2'b00, B_SB);
        add(R,    1,  2,  0,  0,    0,    2'b00, B_R);
        add(R,    1,  2,  0,  0,    0,    2'b00, B_R);

        #12;
        chk_all_zero("reset");
        chk("reset flush", int'(flush_if_id), 0);
        chk("reset jump", int'(id_jump), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].op, tv[i].rs, tv[i].rt, tv[i].bt);
            sb_q.push_back(tv[i].ex);
            #1;
            chk($sformatf("row%0d stall", i), int'(stall), int'(tv[i].stall));
            chk($sformatf("row%0d flush", i), int'(flush_if_id), int'(tv[i].flush));
            chk($sformatf("row%0d jump", i), int'(id_jump), int'(tv[i].jump));
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                chk($sformatf("row%0d scoreboard empty", i), 1, 0);
                exp_b = B_Z;
            end else begin
                exp_b = sb_q.pop_front();
            end
            chk($sformatf("row%0d ex", i),
                int'({ex_reg_dst, ex_alu_src, ex_alu_op, ex_imm_op, ex_branch, illegal_op}),
                int'(ex_part(exp_b)));
            chk($sformatf("row%0d mem", i), int'({mem_mem_read, mem_mem_write}), int'(mem_part(prev1)));
            chk($sformatf("row%0d wb", i), int'({wb_reg_write, wb_memto_reg}), int'(wb_part(prev2)));
            prev2 = prev1;
            prev1 = exp_b;
            @(negedge clk);
        end

        // Immediate and jump opcodes on the variant with both disabled
        drive(ADDI, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        chk("imm1 ex alusrc", int'(ex_alu_src), 1);
        chk("imm1 ex aluop", int'(ex_alu_op), 2);
        chk("imm1 ex immop", int'(ex_imm_op), 0);
        chk("imm1 illegal", int'(illegal_op), 0);
        chk("imm0 illegal", int'(illegal_op2), 1);
        chk("imm0 ex", int'({ex_reg_dst2, ex_alu_src2, ex_alu_op2, ex_imm_op2, ex_branch2}), 0);
        @(negedge clk);
        drive(J, 5'd0, 5'd0, 1'b0);
        #1;
        chk("jmp0 idjump", int'(id_jump2), 0);
        chk("jmp0 flush", int'(flush_if_id2), 0);
        chk("jmp1 idjump", int'(id_jump), 1);
        @(posedge clk);
        #1;
        chk("jmp0 illegal", int'(illegal_op2), 1);
        @(negedge clk);
        drive(R, 5'd1, 5'd2, 1'b0);
        @(posedge clk);
        #1;
        chk("illegal pulse end", int'(illegal_op2), 0);

        // Asynchronous reset with a load in EX and a load-use pending
        @(negedge clk);
        drive(LW, 5'd1, 5'd5, 1'b0);
        @(posedge clk);
        #1;
        chk("rst lw in ex", int'(ex_alu_src), 1);
        @(negedge clk);
        drive(R, 5'd5, 5'd1, 1'b0);
        #1;
        chk("rst pre stall", int'(stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async rst");
        @(negedge clk);
        chk_all_zero("held rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst release ex regdst", int'(ex_reg_dst), 1);
        chk("rst release mem", int'({mem_mem_read, mem_mem_write}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Main control for the 5-stage MIPS pipeline.
- Decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path instructions on a taken branch or a jump.
- Successor to the purely combinational decoder: adds pipelining, stall/flush handling, optional immediate/jump decode and illegal-opcode reporting.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register-index width
SUPPORT_IMM, 1, 1 = decode addi/andi/ori/slti/lui; 0 = treat them as illegal
SUPPORT_JUMP, 1, 1 = decode j/jal; 0 = treat them as illegal

Ports:
clk  in  1  clock, all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
Opcode  in  OP_W  ID-stage instruction [31:26]
IdRs  in  REG_W  ID-stage rs field
IdRt  in  REG_W  ID-stage rt field
BranchTaken  in  1  branch resolved taken in EX (from datapath)
Stall  out  1  hold PC and IF/ID register (combinational)
FlushIfId  out  1  clear IF/ID register on next edge (combinational)
IdJump  out  2  00 none, 01 j, 10 jal (combinational)
ExRegDst  out  1  EX-stage control
ExALUSrc  out  1  EX-stage control
ExALUOp  out  2  EX-stage control
ExImmOp  out  3  Opcode[2:0] of the immediate ALU op, else 0
ExBranch  out  2  00 none, 01 beq, 10 bne, 11 bgez
MemMemRead  out  2  00 none, 01 lw, 10 lb, 11 lh
MemMemWrite  out  2  00 none, 01 sw, 10 sb, 11 sh
WbRegWrite  out  1  WB-stage control
WbMemtoReg  out  1  WB-stage control
IllegalOp  out  1  registered one-cycle pulse on an undecoded opcode

Behaviour:
Reset:
- rst_n is asynchronous, active-low; clk is the only clock.
- rst_n low clears every pipeline register: all Ex*/Mem*/Wb* outputs and IllegalOp read 0 (a bubble).
- Reset asserted mid-operation discards in-flight bundles immediately, without waiting for a clock edge.

Decode (combinational, ID stage); unlisted fields are 0:
- 000000 R-type: RegDst=1, RegWrite=1, ALUOp=00.
- 100011 lw / 100000 lb / 100001 lh: ALUSrc=1, ALUOp=01, MemtoReg=1, RegWrite=1, MemRead=01/10/11.
- 101011 sw / 101000 sb / 101001 sh: ALUSrc=1, ALUOp=01, MemWrite=01/10/11.
- 000100 beq / 000101 bne / 000001 bgez: ALUOp=01, Branch=01/10/11.
- SUPPORT_IMM: 001000 addi, 001100 andi, 001101 ori, 001010 slti, 001111 lui give ALUSrc=1, ALUOp=10, RegWrite=1, ImmOp=Opcode[2:0].
- SUPPORT_JUMP: 000010 j gives IdJump=01; 000011 jal gives IdJump=10. Both leave an all-zero bundle (link write handled elsewhere).
- Any other opcode, or a disabled one: all-zero bundle, and IllegalOp pulses 1 the cycle the bundle enters EX.

Pipeline:
- Every edge: EX<=ID bundle, MEM<=EX, WB<=MEM.
- Latency from ID decode: Ex* at +1 cycle, Mem* at +2, Wb* at +3.
- The registered rt index (ExRt) travels with the EX bundle.

Load-use hazard (combinational):
- Stall = ExMemRead != 0 AND ExRt != 0 AND (ExRt == IdRs OR (ExRt == IdRt AND the ID op reads rt)).
- Ops that read rt: R-type, stores, beq, bne.
- While Stall is high, EX loads a bubble instead of the ID bundle; MEM and WB advance normally.

Control hazards:
- BranchTaken=1 forces FlushIfId=1 and EX loads a bubble.
- BranchTaken forces Stall=0 (the ID instruction is wrong-path) and gates IdJump to 00.
- IdJump != 00 forces FlushIfId=1; the jump's own zero bundle still enters EX.

Priority: reset > BranchTaken > Stall > normal.

Back-to-back hazards:
- A bubble in EX cannot trigger a second stall, so each load-use costs exactly one cycle.
- A stalled load's consumer re-presents in ID and then proceeds normally.

Test Plan:
- Reset: rst_n low mid-stream with lw in EX -> all outputs 0 asynchronously; first edge after release loads the current ID bundle.
- Pipeline latency: lw, sw, add issued on consecutive cycles -> MemMemRead=01 at cycle 2; MemMemWrite=01 at cycle 3; WbRegWrite=1, WbMemtoReg=0 for add at cycle 5.
- Load-use on rs: lw rt=5 then add rs=5 -> Stall=1 for exactly one cycle; Ex bundle all-zero that cycle; add reaches EX on the following cycle with ExRegDst=1.
- Load-use exclusions: lw rt=0 then add rs=0 -> Stall=0. lw rt=5 then addi rt=5 (rt is a destination) -> Stall=0.
- Flush: beq in EX with BranchTaken=1 while a load-use condition holds -> Stall=0, FlushIfId=1, next Ex bundle zero. j in ID -> IdJump=01, FlushIfId=1.
- Illegal opcode: 001000 with SUPPORT_IMM=0, and 111111 -> zero bundle, IllegalOp=1 for one cycle; with SUPPORT_IMM=1, 001000 -> ExALUSrc=1, ExALUOp=10, ExImmOp=000.
